slave_write_arbiter: RTL and testbench

- Shares the single 16-bit write port (in_data/in_enable) of the FPGA slave receiver among N_REQ on-chip producers.
- Grants one producer at a time, round-robin, and issues a one-cycle in_enable pulse carrying that producer's word.
- Holds off the next write until the slave's dirty flag has risen (word captured) and fallen again (ARM drained it over from_ARM/to_ARM).
- Flags a timeout if the slave never acknowledges a write with dirty.

---
 rtl/slave_write_arbiter_if.sv | 27 ++
 rtl/slave_write_arbiter.sv | 124 ++++++++++++
 tb/tb_slave_write_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_write_arbiter_if.sv
// rtl/slave_write_arbiter_if.sv - requester and slave-port signals of the write arbiter
// master: arbiter side; slave: the producers plus the FPGA slave receiver.
interface slave_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    slave_dirty;
  logic [DATA_W-1:0]       slave_in_data;
  logic                    slave_in_enable;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;
  logic                    timeout_err;

  modport master (
    input  req, req_data, slave_dirty,
    output ack, slave_in_data, slave_in_enable, grant_id, busy, timeout_err
  );

  modport slave (
    output req, req_data, slave_dirty,
    input  ack, slave_in_data, slave_in_enable, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/slave_write_arbiter.sv
// rtl/slave_write_arbiter.sv - round-robin arbiter sharing the slave in_data/in_enable write port
// One word in flight: issue, wait for dirty to rise (captured), then fall (drained by ARM).
module slave_write_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_write_arbiter_if.master bus
);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_SET,
    WAIT_CLR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                en_q, en_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                tmo_q, tmo_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;

  // Scan starts just after the last grantee so a persistent requester waits its turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_ptr_q) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ptr_d = last_ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    en_d       = 1'b0;
    ack_d      = '0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // A dirty buffer left over from before means the slave is not ready for us.
        if (!bus.slave_dirty && pick_valid) begin
          data_d     = bus.req_data[int'(pick_idx) * DATA_W +: DATA_W];
          grant_d    = pick_idx;
          last_ptr_d = pick_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        en_d           = 1'b1;
        ack_d[grant_q] = 1'b1;
        cnt_d          = '0;
        state_d        = WAIT_SET;
      end
      WAIT_SET: begin
        if (bus.slave_dirty) begin
          state_d = WAIT_CLR;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_CLR: begin
        if (!bus.slave_dirty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
      grant_q    <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      ack_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ptr_q <= last_ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.ack             = ack_q;
  assign bus.slave_in_data   = data_q;
  assign bus.slave_in_enable = en_q;
  assign bus.grant_id        = grant_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.timeout_err     = tmo_q;
endmodule

// File: tb/tb_slave_write_arbiter.sv
// tb/tb_slave_write_arbiter.sv - bench for slave_write_arbiter: vector table, directed corners, random vs model
// Model tracks transfers as arithmetic on edge numbers, not as states.
module tb_slave_write_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int TMO = 8;
  localparam int IW  = 2;
  localparam int FAR = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  rq = '0;
  logic          dirty = 1'b0;
  logic [N*DW-1:0] rd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slave_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  assign bus.req         = rq;
  assign bus.req_data    = rd;
  assign bus.slave_dirty = dirty;

  slave_write_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          dirty;
    logic          en;
    logic [N-1:0]  ack;
    logic [IW-1:0] gid;
    logic          busy;
    logic          tmo;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [N-1:0] q, input logic d, input logic e,
                     input logic [N-1:0] a, input logic [IW-1:0] g, input logic b,
                     input logic t, input logic [DW-1:0] dt);
    vec_t v;
    v.rst = r; v.req = q; v.dirty = d; v.en = e; v.ack = a;
    v.gid = g; v.busy = b; v.tmo = t; v.data = dt;
    tbl.push_back(v);
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] q);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (ptr + k) % N;
      if (q[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk_all(input string tag, input logic e, input logic [N-1:0] a,
                         input int g, input logic b, input logic t, input logic [DW-1:0] dt);
    chk({tag, ".en"},   bus.slave_in_enable, e);
    chk({tag, ".ack"},  bus.ack, a);
    chk({tag, ".gid"},  bus.grant_id, g);
    chk({tag, ".busy"}, bus.busy, b);
    chk({tag, ".tmo"},  bus.timeout_err, t);
    chk({tag, ".data"}, bus.slave_in_data, dt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants;
    int en_at;
    int order [5];
    // ---------------- vector table: single requester, then stale dirty ----------------
    rd = {16'h3333, 16'h2222, 16'h00F3, 16'h1111};
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 16'h0000);
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0, 0, 16'h0000);
    add(1, 4'b0010, 0, 0, 4'b0000, 1, 1, 0, 16'h00F3);
    add(1, 4'b0010, 0, 1, 4'b0010, 1, 1, 0, 16'h00F3);
    add(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 16'h00F3);
    for (int k = 0; k < 10; k++) add(1, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 16'h00F3);
    add(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 16'h00F3);
    add(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 16'h00F3);
    add(0, 4'b0001, 1, 0, 4'b0000, 0, 0, 0, 16'h0000);
    add(1, 4'b0001, 1, 0, 4'b0000, 0, 0, 0, 16'h0000);
    add(1, 4'b0001, 1, 0, 4'b0000, 0, 0, 0, 16'h0000);
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 1, 0, 16'h1111);
    add(1, 4'b0001, 0, 1, 4'b0001, 0, 1, 0, 16'h1111);
    add(1, 4'b0000, 1, 0, 4'b0000, 0, 1, 0, 16'h1111);
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 16'h1111);
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; rq = tbl[k].req; dirty = tbl[k].dirty;
      tick();
      chk_all($sformatf("row%0d", k), tbl[k].en, tbl[k].ack, int'(tbl[k].gid),
              tbl[k].busy, tbl[k].tmo, tbl[k].data);
    end

    // ---------------- timeout, then rotation from the timed-out grantee ----------------
    rst = 1'b0; rq = 4'b0000; dirty = 1'b0;
    tick();
    rst = 1'b1; rq = 4'b0100;
    tick();
    chk("tmo.grant_gid", bus.grant_id, 2);
    tick();
    chk("tmo.issue_en", bus.slave_in_enable, 1);
    chk("tmo.issue_ack", bus.ack, 4'b0100);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      chk($sformatf("tmo.err_c%0d", k), bus.timeout_err, (k == TMO));
    end
    chk("tmo.idle_busy", bus.busy, 0);
    tick();
    chk("tmo.regrant_gid", bus.grant_id, 2);
    chk("tmo.regrant_err", bus.timeout_err, 0);
    tick();
    chk("tmo.regrant_ack", bus.ack, 4'b0100);
    rq = 4'b1100; dirty = 1'b1;
    tick();
    dirty = 1'b0;
    tick();
    chk("tmo.drain_busy", bus.busy, 0);
    tick();
    chk("tmo.next_gid", bus.grant_id, 3);
    tick();
    chk("tmo.next_ack", bus.ack, 4'b1000);
    rq = 4'b0000; dirty = 1'b1;
    tick();
    dirty = 1'b0;
    tick();
    tick();
    chk("tmo.end_busy", bus.busy, 0);

    // ---------------- all four held: order 0,1,2,3,0, then reset in WAIT_CLR ----------------
    order = '{0, 1, 2, 3, 0};
    rd = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    rst = 1'b0; rq = 4'b1111; dirty = 1'b0;
    tick();
    rst = 1'b1;
    grants = 0;
    en_at = -100;
    for (int c = 1; c <= 120 && grants < 5; c++) begin
      tick();
      if (bus.slave_in_enable) begin
        chk($sformatf("rot%0d.dirty_low", grants), dirty, 0);
        chk($sformatf("rot%0d.gid", grants), bus.grant_id, order[grants]);
        chk($sformatf("rot%0d.ack", grants), bus.ack, 1 << order[grants]);
        chk($sformatf("rot%0d.data", grants), bus.slave_in_data, 16'hA000 + order[grants]);
        grants++;
        en_at = c;
      end else if (bus.ack != '0) begin
        chk($sformatf("rot.stray_ack_c%0d", c), bus.ack, 0);
      end
      dirty = (en_at > 0) && (c + 1 - en_at >= 1) && (c + 1 - en_at <= 5) && (grants < 5);
    end
    chk("rot.grant_count", grants, 5);
    dirty = 1'b1;
    tick();
    tick();
    chk("rst.wait_clr_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    chk_all("rst.mid", 0, 4'b0000, 0, 0, 0, 16'h0000);
    rst = 1'b1; dirty = 1'b0;
    tick();
    chk("rst.after_data", bus.slave_in_data, 16'hA000);
    tick();
    chk("rst.after_ack", bus.ack, 4'b0001);
    rq = 4'b0000; dirty = 1'b1;
    tick();
    dirty = 1'b0;
    tick();
    tick();

    // ---------------- random traffic vs transfer-level model ----------------
    begin
      int next_free, grant_at, g_edge, exp_g, ptr, rr, hh, nwr;
      logic [DW-1:0] exp_d;
      logic exp_en, exp_busy;
      rst = 1'b0; rq = '0; dirty = 1'b0;
      tick();
      rst = 1'b1;
      next_free = 1; grant_at = -100; g_edge = -100; exp_g = 0; exp_d = '0;
      ptr = N - 1; en_at = -100; rr = 1; hh = 1; nwr = 0;
      for (int i = 0; i < 3000; i++) begin
        exp_en = (grant_at == i - 1);
        if (exp_en) begin
          en_at = i;
          rr = $urandom_range(1, 3);
          hh = $urandom_range(1, 4);
          next_free = i + rr + hh + 1;
          nwr++;
          chk($sformatf("rnd%0d.en", i), bus.slave_in_enable, 1);
          chk($sformatf("rnd%0d.gid", i), bus.grant_id, exp_g);
          chk($sformatf("rnd%0d.ack", i), bus.ack, 1 << exp_g);
          chk($sformatf("rnd%0d.data", i), bus.slave_in_data, exp_d);
          rq[exp_g] = 1'($urandom_range(0, 1));
          rd[exp_g*DW +: DW] = DW'($urandom);
        end else begin
          chk($sformatf("rnd%0d.en", i), bus.slave_in_enable, 0);
          chk($sformatf("rnd%0d.ack", i), bus.ack, 0);
        end
        exp_busy = (i >= g_edge) && (i <= next_free - 2);
        chk($sformatf("rnd%0d.busy", i), bus.busy, exp_busy);
        chk($sformatf("rnd%0d.tmo", i), bus.timeout_err, 0);
        dirty = (i + 1 >= en_at + rr) && (i + 1 < en_at + rr + hh);
        for (int j = 0; j < N; j++) begin
          if (!rq[j]) begin
            rd[j*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 3) == 0) rq[j] = 1'b1;
          end else if (grant_at == i && j == exp_g) begin
            rd[j*DW +: DW] = DW'($urandom);
          end else if (!(grant_at == i && j == exp_g) && $urandom_range(0, 31) == 0) begin
            rq[j] = 1'b0;
          end
        end
        if (i + 1 >= next_free && rq != '0 && !dirty) begin
          exp_g = rr_pick(ptr, rq);
          exp_d = rd[exp_g*DW +: DW];
          ptr = exp_g;
          grant_at = i + 1;
          g_edge = i + 1;
          next_free = FAR;
        end
        tick();
      end
      chk("rnd.activity", (nwr > 100), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
